// File: rtl/minefield_gen.sv
`default_nettype none
// ============================================================================
// Module   : minefield_gen
// Purpose  : Fills a board with pseudo-random mines outside a safe 3x3 area,
//            annotates neighbour counts and serves cells via a read port.
// Revision : 1.0 - initial release
// ============================================================================
module minefield_gen #(
    parameter int          X_SIZE   = 16,
    parameter int          Y_SIZE   = 16,
    parameter int          XB       = 4,
    parameter int          YB       = 4,
    parameter int          CB       = 9,
    parameter logic [31:0] DEF_SEED = 32'h12345678
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [CB-1:0] target_mines_i,
    input  logic [XB-1:0] safe_x_i,
    input  logic [YB-1:0] safe_y_i,
    input  logic          seed_load_i,
    input  logic [31:0]   seed_in_i,
    input  logic [XB-1:0] rd_x_i,
    input  logic [YB-1:0] rd_y_i,
    output logic [4:0]    rd_val_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [CB-1:0] mines_placed_o
);

    localparam int            c_CELLS     = X_SIZE * Y_SIZE;
    localparam int            c_XIW       = $clog2(X_SIZE);
    localparam int            c_YIW       = $clog2(Y_SIZE);
    localparam logic [CB-1:0] c_MAX_MINES = CB'(c_CELLS - 9);
    localparam logic [4:0]    c_MINE      = 5'h1F;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_PLACE = 3'd2,
        S_COUNT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    logic [4:0]    board_q [Y_SIZE][X_SIZE];
    state_t        state_q;
    logic [31:0]   prng_q, prng_d, w_s1, w_s2;
    logic [CB-1:0] tgt_q, mp_q, w_tgt;
    logic [XB-1:0] sx_q, x_q, w_cx;
    logic [YB-1:0] sy_q, y_q, w_cy;
    logic          busy_q, done_q;
    logic [4:0]    rd_val_q, w_rd_val;
    logic          w_in_range, w_in_safe, w_place_ok, w_last;
    logic [3:0]    w_nbr;

    assign w_s1   = prng_q ^ (prng_q << 13);
    assign w_s2   = w_s1 ^ (w_s1 >> 17);
    assign prng_d = w_s2 ^ (w_s2 << 5);

    assign w_tgt  = (target_mines_i > c_MAX_MINES) ? c_MAX_MINES : target_mines_i;
    assign w_cx   = prng_q[XB-1:0];
    assign w_cy   = prng_q[16+YB-1:16];
    assign w_last = (int'(x_q) == X_SIZE - 1) && (int'(y_q) == Y_SIZE - 1);

    always_comb begin
        int dx;
        int dy;
        dx         = int'(w_cx) - int'(sx_q);
        dy         = int'(w_cy) - int'(sy_q);
        w_in_range = (int'(w_cx) < X_SIZE) && (int'(w_cy) < Y_SIZE);
        w_in_safe  = (dx >= -1) && (dx <= 1) && (dy >= -1) && (dy <= 1);
        w_place_ok = w_in_range && !w_in_safe &&
                     (board_q[w_cy[c_YIW-1:0]][w_cx[c_XIW-1:0]] != c_MINE);
    end

    // Edge cells simply skip off-board neighbours; no wrap-around
    always_comb begin
        int nx;
        int ny;
        w_nbr = 4'd0;
        nx    = 0;
        ny    = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                nx = int'(x_q) + dx;
                ny = int'(y_q) + dy;
                if (!(dx == 0 && dy == 0) && nx >= 0 && nx < X_SIZE && ny >= 0 && ny < Y_SIZE) begin
                    if (board_q[ny[c_YIW-1:0]][nx[c_XIW-1:0]] == c_MINE) begin
                        w_nbr = w_nbr + 4'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_rd_val = 5'd0;
        if ((int'(rd_x_i) < X_SIZE) && (int'(rd_y_i) < Y_SIZE)) begin
            w_rd_val = board_q[rd_y_i[c_YIW-1:0]][rd_x_i[c_XIW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        case (state_q)
            S_CLEAR: board_q[y_q[c_YIW-1:0]][x_q[c_XIW-1:0]] <= 5'd0;
            S_PLACE: if (w_place_ok) board_q[w_cy[c_YIW-1:0]][w_cx[c_XIW-1:0]] <= c_MINE;
            S_COUNT: begin
                if (board_q[y_q[c_YIW-1:0]][x_q[c_XIW-1:0]] != c_MINE) begin
                    board_q[y_q[c_YIW-1:0]][x_q[c_XIW-1:0]] <= {1'b0, w_nbr};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            prng_q   <= DEF_SEED;
            tgt_q    <= '0;
            mp_q     <= '0;
            sx_q     <= '0;
            sy_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_val_q <= 5'd0;
        end else begin
            rd_val_q <= w_rd_val;
            case (state_q)
                S_IDLE: begin
                    if (seed_load_i) begin
                        prng_q <= (seed_in_i == 32'd0) ? DEF_SEED : seed_in_i;
                    end
                    if (start_i) begin
                        tgt_q   <= w_tgt;
                        sx_q    <= safe_x_i;
                        sy_q    <= safe_y_i;
                        mp_q    <= '0;
                        x_q     <= '0;
                        y_q     <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_CLEAR;
                    end
                end
                S_CLEAR, S_COUNT: begin
                    if (w_last) begin
                        x_q <= '0;
                        y_q <= '0;
                        if (state_q == S_COUNT) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= (tgt_q == '0) ? S_COUNT : S_PLACE;
                        end
                    end else if (int'(x_q) == X_SIZE - 1) begin
                        x_q <= '0;
                        y_q <= y_q + YB'(1);
                    end else begin
                        x_q <= x_q + XB'(1);
                    end
                end
                S_PLACE: begin
                    prng_q <= prng_d;
                    if (w_place_ok) begin
                        mp_q <= mp_q + CB'(1);
                        if ((mp_q + CB'(1)) == tgt_q) begin
                            state_q <= S_COUNT;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_val_o       = rd_val_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign mines_placed_o = mp_q;

endmodule
`default_nettype wire

// File: tb/tb_minefield_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_minefield_gen
// Purpose  : Self-checking bench for minefield_gen against a generation model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_minefield_gen;

    localparam logic [31:0] c_DEF_SEED = 32'h12345678;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [8:0]  target_mines_i = '0;
    logic [3:0]  safe_x_i = '0;
    logic [3:0]  safe_y_i = '0;
    logic        seed_load_i = 1'b0;
    logic [31:0] seed_in_i = '0;
    logic [3:0]  rd_x_i = '0;
    logic [3:0]  rd_y_i = '0;
    logic [4:0]  rd_val_o;
    logic        busy_o;
    logic        done_o;
    logic [8:0]  mines_placed_o;

    minefield_gen dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .target_mines_i (target_mines_i),
        .safe_x_i       (safe_x_i),
        .safe_y_i       (safe_y_i),
        .seed_load_i    (seed_load_i),
        .seed_in_i      (seed_in_i),
        .rd_x_i         (rd_x_i),
        .rd_y_i         (rd_y_i),
        .rd_val_o       (rd_val_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .mines_placed_o (mines_placed_o)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [4:0] sb_q[$];
    logic [4:0] act_q[$];
    logic [4:0] exp_board [16][16];
    logic [4:0] got_a [16][16];
    logic [4:0] prev_a [16][16];
    int         exp_place;

    function automatic logic [31:0] xs(input logic [31:0] s);
        s = s ^ (s << 13);
        s = s ^ (s >> 17);
        s = s ^ (s << 5);
        return s;
    endfunction

    // Reference generation: placement walk plus neighbour annotation
    task automatic model(input logic [31:0] seed, input int tgt_raw, input int sx, input int sy);
        int          tgt;
        int          placed;
        int          cx, cy, n, nx, ny;
        logic [31:0] s;
        tgt       = (tgt_raw > 247) ? 247 : tgt_raw;
        placed    = 0;
        s         = (seed == 32'd0) ? c_DEF_SEED : seed;
        exp_place = 0;
        for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) exp_board[y][x] = 5'd0;
        while (placed < tgt) begin
            cx = int'(s[3:0]);
            cy = int'(s[19:16]);
            exp_place++;
            if (exp_board[cy][cx] != 5'h1F &&
                !((cx - sx) >= -1 && (cx - sx) <= 1 && (cy - sy) >= -1 && (cy - sy) <= 1)) begin
                exp_board[cy][cx] = 5'h1F;
                placed++;
            end
            s = xs(s);
        end
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                if (exp_board[y][x] != 5'h1F) begin
                    n = 0;
                    for (int dy = -1; dy <= 1; dy++) begin
                        for (int dx = -1; dx <= 1; dx++) begin
                            nx = x + dx;
                            ny = y + dy;
                            if (!(dx == 0 && dy == 0) && nx >= 0 && nx < 16 && ny >= 0 && ny < 16)
                                if (exp_board[ny][nx] == 5'h1F) n++;
                        end
                    end
                    exp_board[y][x] = 5'(n);
                end
            end
        end
    endtask

    task automatic run_gen(input logic [31:0] seed, input int tgt, input int sx, input int sy,
                           input int disturb_at, output int cycles, output bit timeout);
        seed_in_i   = seed;
        seed_load_i = 1'b1;
        @(posedge clk); #1;
        seed_load_i    = 1'b0;
        target_mines_i = 9'(tgt);
        safe_x_i       = 4'(sx);
        safe_y_i       = 4'(sy);
        start_i        = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        cycles  = 0;
        timeout = 1'b0;
        while (done_o !== 1'b1 && !timeout) begin
            if (cycles == disturb_at || cycles == disturb_at + 250) begin
                start_i        = 1'b1;
                seed_load_i    = 1'b1;
                seed_in_i      = 32'hCAFEF00D;
                target_mines_i = 9'd5;
                safe_x_i       = 4'd12;
            end
            @(posedge clk); #1;
            start_i     = 1'b0;
            seed_load_i = 1'b0;
            cycles++;
            if (cycles > 20000) timeout = 1'b1;
        end
    endtask

    // Reads every cell; expectation queued at address drive, result at output
    task automatic scan_board();
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                rd_x_i = 4'(x);
                rd_y_i = 4'(y);
                sb_q.push_back(exp_board[y][x]);
                @(posedge clk); #1;
                act_q.push_back(rd_val_o);
                got_a[y][x] = rd_val_o;
            end
        end
    endtask

    task automatic test_reset();
        int cyc;
        n_tests++;
        if ({busy_o, done_o, mines_placed_o, rd_val_o} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b mp=%0d rd=%h, need all 0", busy_o, done_o, mines_placed_o, rd_val_o);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        target_mines_i = 9'd40;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        n_tests++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_midrun: busy=%b, need 1", busy_o);
        end
        reset = 1'b1;
        #2;
        n_tests++;
        if ({busy_o, done_o, mines_placed_o, rd_val_o} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_midrun: busy=%b done=%b mp=%0d rd=%h, need all 0", busy_o, done_o, mines_placed_o, rd_val_o);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        cyc = 0;
        n_tests++;
        if ({busy_o, done_o, mines_placed_o} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b done=%b mp=%0d, need all 0", busy_o, done_o, mines_placed_o);
        end
    endtask

    task automatic test_basic();
        int cyc, mines, safe_m, idx;
        bit to;
        logic [4:0] e, a;
        model(32'hDEADBEEF, 40, 0, 0);
        run_gen(32'hDEADBEEF, 40, 0, 0, -1000, cyc, to);
        n_tests++;
        if (to || cyc != 513 + exp_place) begin
            n_fail++;
            $display("FAIL basic_latency: cycles=%0d timeout=%b, need %0d", cyc, to, 513 + exp_place);
        end
        n_tests++;
        if (done_o !== 1'b1 || mines_placed_o !== 9'd40) begin
            n_fail++;
            $display("FAIL basic_count: done=%b mp=%0d, need done=1 mp=40", done_o, mines_placed_o);
        end
        scan_board();
        idx = 0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = act_q.pop_front();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL basic_cell[%0d]: got %h, need %h", idx, a, e);
            end
            idx++;
        end
        mines = 0;
        safe_m = 0;
        for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) if (got_a[y][x] == 5'h1F) mines++;
        for (int y = 0; y < 2; y++) for (int x = 0; x < 2; x++) if (got_a[y][x] == 5'h1F) safe_m++;
        n_tests++;
        if (mines != 40 || safe_m != 0) begin
            n_fail++;
            $display("FAIL basic_mines: total=%0d safe_zone=%0d, need 40 and 0", mines, safe_m);
        end
    endtask

    task automatic test_zero_target();
        int cyc, idx;
        bit to;
        logic [4:0] e, a;
        model(32'h00C0FFEE, 0, 4, 4);
        run_gen(32'h00C0FFEE, 0, 4, 4, -1000, cyc, to);
        n_tests++;
        if (to || cyc != 513 || mines_placed_o !== 9'd0) begin
            n_fail++;
            $display("FAIL zero_latency: cycles=%0d mp=%0d, need 513 and 0", cyc, mines_placed_o);
        end
        scan_board();
        idx = 0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = act_q.pop_front();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL zero_cell[%0d]: got %h, need %h", idx, a, e);
            end
            idx++;
        end
    endtask

    task automatic test_clamp();
        int cyc, idx, safe_m;
        bit to;
        logic [4:0] e, a;
        model(32'h13579BDF, 300, 7, 7);
        run_gen(32'h13579BDF, 300, 7, 7, -1000, cyc, to);
        n_tests++;
        if (to || mines_placed_o !== 9'd247 || cyc != 513 + exp_place) begin
            n_fail++;
            $display("FAIL clamp_count: mp=%0d cycles=%0d, need 247 and %0d", mines_placed_o, cyc, 513 + exp_place);
        end
        scan_board();
        idx = 0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = act_q.pop_front();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL clamp_cell[%0d]: got %h, need %h", idx, a, e);
            end
            idx++;
        end
        safe_m = 0;
        for (int y = 6; y <= 8; y++) for (int x = 6; x <= 8; x++) if (got_a[y][x] == 5'h1F) safe_m++;
        n_tests++;
        if (safe_m != 0) begin
            n_fail++;
            $display("FAIL clamp_safe: mines in safe zone=%0d, need 0", safe_m);
        end
    endtask

    task automatic test_busy_ignore();
        int cyc, idx;
        bit to;
        logic [4:0] e, a;
        model(32'h0BADF00D, 60, 5, 9);
        run_gen(32'h0BADF00D, 60, 5, 9, 100, cyc, to);
        n_tests++;
        if (to || cyc != 513 + exp_place || mines_placed_o !== 9'd60) begin
            n_fail++;
            $display("FAIL busy_ignore_run: cycles=%0d mp=%0d, need %0d and 60", cyc, mines_placed_o, 513 + exp_place);
        end
        scan_board();
        idx = 0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = act_q.pop_front();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL busy_ignore_cell[%0d]: got %h, need %h", idx, a, e);
            end
            idx++;
        end
    endtask

    task automatic test_determinism();
        int c1, c2, diffs;
        bit to1, to2;
        run_gen(32'h2468ACE1, 75, 10, 3, -1000, c1, to1);
        sb_q.delete();
        scan_board();
        prev_a = got_a;
        run_gen(32'h2468ACE1, 75, 10, 3, -1000, c2, to2);
        scan_board();
        sb_q.delete();
        act_q.delete();
        diffs = 0;
        for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) if (got_a[y][x] !== prev_a[y][x]) diffs++;
        model(32'h2468ACE1, 75, 10, 3);
        n_tests++;
        if (to1 || to2 || c1 != c2 || c1 != 513 + exp_place) begin
            n_fail++;
            $display("FAIL determinism_cycles: run1=%0d run2=%0d, need both %0d", c1, c2, 513 + exp_place);
        end
        n_tests++;
        if (diffs != 0) begin
            n_fail++;
            $display("FAIL determinism_board: differing cells=%0d, need 0", diffs);
        end
    endtask

    task automatic test_zero_seed();
        int cyc, idx;
        bit to;
        logic [4:0] e, a;
        model(c_DEF_SEED, 40, 3, 3);
        run_gen(32'd0, 40, 3, 3, -1000, cyc, to);
        n_tests++;
        if (to || cyc != 513 + exp_place) begin
            n_fail++;
            $display("FAIL zero_seed_cycles: cycles=%0d, need %0d", cyc, 513 + exp_place);
        end
        scan_board();
        idx = 0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = act_q.pop_front();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL zero_seed_cell[%0d]: got %h, need %h", idx, a, e);
            end
            idx++;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_zero_target();
        test_clamp();
        test_busy_ignore();
        test_determinism();
        test_zero_seed();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
